// File: rtl/polylut_pkg.sv
// Shared defaults and helpers for the PolyLUT elastic stream pipeline.
// Parity storage is compiled in only when POLYLUT_PIPE_PARITY_EN is defined.
package polylut_pkg;

  localparam int DATA_W_DEF = 112;
  localparam int CNT_W_DEF  = 32;

`ifdef POLYLUT_PIPE_PARITY_EN
  localparam int PAR_W = 1;

  typedef struct packed {
    logic                  valid;
    logic [DATA_W_DEF-1:0] data;
    logic                  parity;
  } slot_t;
`else
  localparam int PAR_W = 0;

  typedef struct packed {
    logic                  valid;
    logic [DATA_W_DEF-1:0] data;
  } slot_t;
`endif

  // Occupancy counts every stage plus an optional skid entry.
  function automatic int occ_w(input int stages);
    return $clog2(stages + 2);
  endfunction

endpackage

// File: rtl/polylut_pipe_slot.sv
// One valid/data register of the elastic pipeline: loads on ld_i, clears on flush.
// Used for every pipeline stage and for the optional input skid entry.
module polylut_pipe_slot
  import polylut_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         ld_i,
  input  logic         d_valid_i,
  input  logic [W-1:0] d_data_i,
  output logic         q_valid_o,
  output logic [W-1:0] q_data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (ld_i) begin
      valid_q <= d_valid_i;
      // Payload only moves with a real beat, so empty loads do not toggle data.
      if (d_valid_i) data_q <= d_data_i;
    end
  end

  assign q_valid_o = valid_q;
  assign q_data_o  = data_q;

endmodule

// File: rtl/polylut_stream_pipe.sv
// Elastic valid/ready pipeline with bubble collapsing, flush, optional skid and counters.
// Define POLYLUT_PIPE_PARITY_EN to carry an even-parity bit and flag mismatches at the output.
module polylut_stream_pipe
  import polylut_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int STAGES    = 2,
  parameter int REG_READY = 0,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [occ_w(STAGES)-1:0] occupancy,
  output logic [CNT_W-1:0]         out_count,
  output logic                     parity_err
);

  localparam int SW    = DATA_W + PAR_W;
  localparam int OCC_W = occ_w(STAGES);

  logic [SW-1:0]     in_slot;
  logic [STAGES:0]   en;
  logic [STAGES-1:0] st_v;
  logic [SW-1:0]     st_d [STAGES];
  logic              src_v;
  logic [SW-1:0]     src_d;
  logic              xfer_in;
  logic              xfer_out;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

`ifdef POLYLUT_PIPE_PARITY_EN
  assign in_slot = {^in_data, in_data};
`else
  assign in_slot = in_data;
`endif

  // A stage may load when it is empty or its content moves on this cycle.
  always_comb begin
    en         = '0;
    en[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      en[i] = ~st_v[i] | en[i+1];
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic          d_v;
    logic [SW-1:0] d_d;
    if (i == 0) begin : g_head
      assign d_v = src_v;
      assign d_d = src_d;
    end else begin : g_body
      assign d_v = st_v[i-1];
      assign d_d = st_d[i-1];
    end
    polylut_pipe_slot #(.W(SW)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .ld_i      (en[i]),
      .d_valid_i (d_v),
      .d_data_i  (d_d),
      .q_valid_o (st_v[i]),
      .q_data_o  (st_d[i])
    );
  end

  if (REG_READY != 0) begin : g_skid
    logic          skid_v;
    logic [SW-1:0] skid_d;
    logic          skid_ld;
    // Fill when a beat lands while stage 0 is blocked; empty when stage 0 takes it.
    assign skid_ld = skid_v ? en[0] : ~en[0];
    polylut_pipe_slot #(.W(SW)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .ld_i      (skid_ld),
      .d_valid_i (~skid_v & xfer_in),
      .d_data_i  (in_slot),
      .q_valid_o (skid_v),
      .q_data_o  (skid_d)
    );
    assign src_v    = skid_v | xfer_in;
    assign src_d    = skid_v ? skid_d : in_slot;
    assign in_ready = rst & ~flush & ~skid_v;
  end else begin : g_comb
    assign src_v    = xfer_in;
    assign src_d    = in_slot;
    assign in_ready = rst & ~flush & en[0];
  end

  assign out_valid = st_v[STAGES-1] & ~flush;
  assign out_data  = st_d[STAGES-1][DATA_W-1:0];
  assign xfer_in   = in_valid & in_ready;
  assign xfer_out  = out_valid & out_ready;

  always_comb begin
    occ_d = occ_q;
    cnt_d = cnt_q;
    if (flush) begin
      occ_d = '0;
      cnt_d = '0;
    end else begin
      if (xfer_in & ~xfer_out) occ_d = occ_q + OCC_W'(1);
      else if (~xfer_in & xfer_out) occ_d = occ_q - OCC_W'(1);
      if (xfer_out) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= '0;
      cnt_q <= '0;
    end else begin
      occ_q <= occ_d;
      cnt_q <= cnt_d;
    end
  end

  assign occupancy = occ_q;
  assign out_count = cnt_q;

`ifdef POLYLUT_PIPE_PARITY_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (flush) err_d = 1'b0;
    else if (xfer_out && (^st_d[STAGES-1])) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign parity_err = err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_polylut_stream_pipe.sv
// Self-checking bench: two instances (combinational ready and skid ready), a queue
// scoreboard model, a directed vector table and randomized streaming.
module tb_polylut_stream_pipe;

  localparam int DW   = 16;
  localparam int ST   = 3;
  localparam int CW   = 5;
  localparam int OW   = 3;
  localparam int CMOD = 32;

  typedef struct {
    logic          iv;
    logic          orr;
    logic          fl;
    logic [DW-1:0] d;
    logic          rdy;
    logic          ov;
    logic [DW-1:0] od;
    int            occ;
    int            cnt;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    flush, in_valid, in_ready, out_valid, out_ready, perr;
  logic [DW-1:0] in_data  [2];
  logic [DW-1:0] out_data [2];
  logic [OW-1:0] occ [2];
  logic [CW-1:0] cnt [2];

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] mq[$];
  int            popped[2];
  logic          hold_pending;
  logic [DW-1:0] held_data;
  vec_t          vecs[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    polylut_stream_pipe #(.DATA_W(DW), .STAGES(ST), .REG_READY(g), .CNT_W(CW)) u_dut (
      .clk        (clk),
      .rst        (rst_n),
      .flush      (flush[g]),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_data    (in_data[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .out_data   (out_data[g]),
      .occupancy  (occ[g]),
      .out_count  (cnt[g]),
      .parity_err (perr[g])
    );
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic iv, input logic orr, input logic fl, input logic [DW-1:0] d,
                         input logic rdy, input logic ov, input logic [DW-1:0] od,
                         input int o, input int c);
    vec_t v;
    v.iv = iv; v.orr = orr; v.fl = fl; v.d = d;
    v.rdy = rdy; v.ov = ov; v.od = od; v.occ = o; v.cnt = c;
    vecs.push_back(v);
  endtask

  // One clock on instance k: check against the model before the edge, update it after.
  task automatic tick(input int k, output logic ai, output logic ao);
    logic          fl, exp_rdy;
    logic [DW-1:0] di;
    int            sz;
    @(negedge clk);
    fl = flush[k];
    sz = mq.size();
    di = in_data[k];
    if (k == 0) exp_rdy = !fl && !(sz == ST && !out_ready[k]);
    else        exp_rdy = !fl && (sz != ST + 1);
    chk("in_ready", in_ready[k], exp_rdy);
    chk("occupancy", occ[k], sz);
    chk("out_count", cnt[k], popped[k] % CMOD);
    chk("parity_err", perr[k], 0);
    if (fl) chk("flush_out_valid", out_valid[k], 0);
    if (hold_pending && !fl) begin
      chk("hold_valid", out_valid[k], 1);
      chk("hold_data", out_data[k], held_data);
    end
    if (out_valid[k]) begin
      chk("out_nonempty", sz != 0, 1);
      if (sz != 0) chk("out_order", out_data[k], mq[0]);
    end
    ai = in_valid[k] & in_ready[k];
    ao = out_valid[k] & out_ready[k];
    hold_pending = out_valid[k] & ~out_ready[k] & ~fl;
    held_data = out_data[k];
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
      popped[k] = 0;
      hold_pending = 1'b0;
    end else begin
      if (ao && sz != 0) begin
        void'(mq.pop_front());
        popped[k]++;
      end
      if (ai) mq.push_back(di);
    end
  endtask

  task automatic run_stream(input int k, input int n, input int exp_cnt);
    int sent = 0, got = 0, cyc = 0, t_acc = -1, t_out = -1;
    logic ai, ao;
    out_ready[k] = 1'b1;
    while ((sent < n || got < n) && cyc < 100) begin
      in_valid[k] = (sent < n);
      in_data[k]  = DW'(sent + 1);
      tick(k, ai, ao);
      if (ai && t_acc < 0) t_acc = cyc;
      if (ao && t_out < 0) t_out = cyc;
      sent += int'(ai);
      got  += int'(ao);
      cyc++;
    end
    in_valid[k] = 1'b0;
    chk("stream_latency", t_out - t_acc, ST);
    chk("stream_cycles", cyc, n + ST);
    chk("stream_out_count", cnt[k], exp_cnt);
  endtask

  task automatic fill_drain(input int k, input int exp_n);
    int acc = 0, got = 0, n = 0;
    logic ai, ao;
    out_ready[k] = 1'b0;
    in_valid[k]  = 1'b1;
    in_data[k]   = DW'($urandom);
    for (int i = 0; i < 8; i++) begin
      tick(k, ai, ao);
      acc += int'(ai);
      if (ai) in_data[k] = DW'($urandom);
    end
    in_valid[k] = 1'b0;
    chk("fill_accepted", acc, exp_n);
    chk("fill_occupancy", occ[k], exp_n);
    for (int i = 0; i < 3; i++) tick(k, ai, ao);
    out_ready[k] = 1'b1;
    while (got < exp_n && n < 20) begin
      tick(k, ai, ao);
      got += int'(ao);
      n++;
    end
    tick(k, ai, ao);
    chk("drain_count", got, exp_n);
    chk("drain_occupancy", occ[k], 0);
  endtask

  task automatic run_random(input int k, input int beats);
    int got = 0, cyc = 0;
    logic ai, ao;
    while (got < beats && cyc < 40000) begin
      in_valid[k]  = ($urandom_range(0, 3) != 0);
      out_ready[k] = ($urandom_range(0, 3) != 0);
      flush[k]     = ($urandom_range(0, 699) == 0);
      in_data[k]   = DW'($urandom);
      tick(k, ai, ao);
      got += int'(ao);
      cyc++;
    end
    in_valid[k] = 1'b0;
    out_ready[k] = 1'b0;
    chk("random_beats_done", got >= beats, 1);
    flush[k] = 1'b1;
    tick(k, ai, ao);
    flush[k] = 1'b0;
    tick(k, ai, ao);
  endtask

`ifdef POLYLUT_PIPE_PARITY_EN
  logic [DW:0] par_tmp;
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ai, ao;
    rst_n = 1'b0;
    flush = '0; in_valid = '0; out_ready = '0;
    in_data[0] = '0; in_data[1] = '0;
    popped[0] = 0; popped[1] = 0;
    hold_pending = 1'b0;

    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_in_ready", in_ready[k], 0);
      chk("rst_out_valid", out_valid[k], 0);
      chk("rst_occupancy", occ[k], 0);
      chk("rst_out_count", cnt[k], 0);
      chk("rst_parity_err", perr[k], 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready0", in_ready[0], 1);
    chk("post_rst_ready1", in_ready[1], 1);
    @(posedge clk);
    #1;

    // Combinational-ready instance: fill under stall, release, then flush with two beats held.
    add_vec(1, 0, 0, 16'hA001, 1, 0, 16'h0000, 0, 0);
    add_vec(1, 0, 0, 16'hA002, 1, 0, 16'h0000, 1, 0);
    add_vec(1, 0, 0, 16'hA003, 1, 0, 16'h0000, 2, 0);
    add_vec(1, 0, 0, 16'hA004, 0, 1, 16'hA001, 3, 0);
    add_vec(1, 1, 0, 16'hA004, 1, 1, 16'hA001, 3, 0);
    add_vec(0, 1, 0, 16'h0000, 1, 1, 16'hA002, 3, 1);
    add_vec(0, 0, 0, 16'h0000, 1, 1, 16'hA003, 2, 2);
    add_vec(1, 1, 1, 16'hA005, 0, 0, 16'h0000, 2, 2);
    add_vec(0, 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0);
    foreach (vecs[i]) begin
      in_valid[0]  = vecs[i].iv;
      out_ready[0] = vecs[i].orr;
      flush[0]     = vecs[i].fl;
      in_data[0]   = vecs[i].d;
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", i), in_ready[0], vecs[i].rdy);
      chk($sformatf("tbl%0d_out_valid", i), out_valid[0], vecs[i].ov);
      chk($sformatf("tbl%0d_occupancy", i), occ[0], vecs[i].occ);
      chk($sformatf("tbl%0d_out_count", i), cnt[0], vecs[i].cnt);
      if (vecs[i].ov) chk($sformatf("tbl%0d_out_data", i), out_data[0], vecs[i].od);
      @(posedge clk);
      #1;
    end
    in_valid[0] = 1'b0; out_ready[0] = 1'b0; flush[0] = 1'b0;

    run_stream(0, 16, 16);
    run_stream(0, 16, 0);
    run_stream(1, 16, 16);
    fill_drain(0, ST);
    fill_drain(1, ST + 1);
    run_random(0, 10000);
    run_random(1, 10000);

    // Asynchronous reset with beats in flight.
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_data[0]   = 16'h5A5A;
    tick(0, ai, ao);
    tick(0, ai, ao);
    in_valid[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid[0], 0);
    chk("midrst_occupancy", occ[0], 0);
    chk("midrst_in_ready", in_ready[0], 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mq.delete();
    popped[0] = 0; popped[1] = 0;
    hold_pending = 1'b0;
    tick(0, ai, ao);

`ifdef POLYLUT_PIPE_PARITY_EN
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_data[0]   = 16'h1234;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    par_tmp = g_dut[0].u_dut.g_stage[1].u_slot.data_q;
    force g_dut[0].u_dut.g_stage[1].u_slot.data_q = par_tmp ^ 17'h1;
    #1 release g_dut[0].u_dut.g_stage[1].u_slot.data_q;
    out_ready[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("parity_err_set", perr[0], 1);
    @(posedge clk);
    #1 chk("parity_err_sticky", perr[0], 1);
    flush[0] = 1'b1;
    @(posedge clk);
    #1 flush[0] = 1'b0;
    chk("parity_err_flushed", perr[0], 0);
    out_ready[0] = 1'b0;
    mq.delete();
    popped[0] = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
